// File: rtl/ctrl_pkg.sv
// Shared definitions for the registered control unit: instruction type codes,
// ALU operation codes, immediate-format codes, the control bundle struct and
// the FSM state encoding used by control_unit_pipe.
// Latency: n/a (definitions only). Backpressure: n/a.
package ctrl_pkg;

  // instruction_type codes; 2'b11 is reserved and decodes as illegal
  localparam logic [1:0] TYPE_MEM  = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CTRL = 2'b10;

  // Native ALU operation codes; the top zero-extends these to ALUOP_W
  localparam int         ALU_W   = 3;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_CLI = 3'd6;

  // Immediate formats
  localparam logic [1:0] IMM_BR  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_ALU = 2'b10;

  // Width of the mul/div stretch counter (MULDIV_LAT is at most 15)
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             branch_b;
    logic             branch_i;
    logic             branch_geq;
    logic             branch_leq;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic             reg_write;
    logic             reg_src2;
    logic             reg_src1;
    logic [ALU_W-1:0] alu_op;
    logic [1:0]       imm_src;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_MULDIV = 2'd2
  } ctrl_state_t;

  // All-zero bundle: what illegal encodings and reset produce
  function automatic ctrl_bundle_t ctrl_nop();
    return '0;
  endfunction

  // Multi-cycle operations are identified purely by their ALU code
  function automatic logic ctrl_is_muldiv(input logic [ALU_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/control_unit_pipe_decode.sv
// ctrl_decode: purely combinational instruction-field decoder.
// Latency: 0 cycles (combinational). Backpressure: none, the caller registers.
// Ports: i_type/i_func in -> o_bundle (control bundle, NOP when illegal),
//        o_is_illegal (reserved type, unlisted data func, or func bits above 4 set).
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int FUNC_W = 5
) (
  input  logic [1:0]        i_type,
  input  logic [FUNC_W-1:0] i_func,
  output ctrl_bundle_t      o_bundle,
  output logic              o_is_illegal
);

  logic [4:0]   w_f;
  logic         w_upper_nz;
  logic         w_ill;
  ctrl_bundle_t w_b;

  assign w_f        = i_func[4:0];
  // Any set bit above func[4] makes the encoding illegal
  assign w_upper_nz = (i_func >> 5) != '0;

  always_comb begin
    w_b   = ctrl_nop();
    w_ill = 1'b0;
    case (i_type)
      TYPE_MEM: begin
        w_b.alu_src = 1'b1;
        w_b.alu_op  = ALU_ADD;
        w_b.imm_src = IMM_MEM;
        if (w_f[4]) begin
          w_b.mem_write = 1'b1;
        end else begin
          w_b.mem_read   = 1'b1;
          w_b.mem_to_reg = 1'b1;
          w_b.reg_write  = 1'b1;
        end
      end
      TYPE_DATA: begin
        if (!w_f[4]) begin
          // Register forms: only 00000..00011 exist, func[1:0] is the op
          if (w_f[3:2] == 2'b00) begin
            w_b.alu_op    = {1'b0, w_f[1:0]};
            w_b.reg_write = 1'b1;
          end else begin
            w_ill = 1'b1;
          end
        end else begin
          // Immediate forms 10100..11010 map to ALU codes 0..6
          if ((w_f[3:0] >= 4'd4) && (w_f[3:0] <= 4'd10)) begin
            w_b.alu_op    = ALU_W'(w_f[3:0] - 4'd4);
            w_b.alu_src   = 1'b1;
            w_b.reg_write = 1'b1;
            w_b.imm_src   = IMM_ALU;
          end else begin
            w_ill = 1'b1;
          end
        end
      end
      TYPE_CTRL: begin
        w_b.alu_op   = ALU_SUB;
        w_b.imm_src  = IMM_BR;
        w_b.reg_src2 = 1'b1;
        w_b.reg_src1 = 1'b1;
        case (w_f[4:3])
          2'b00:   w_b.branch_b   = 1'b1;
          2'b10:   w_b.branch_i   = 1'b1;
          2'b01:   w_b.branch_geq = 1'b1;
          default: w_b.branch_leq = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign o_is_illegal = w_ill | w_upper_nz;
  assign o_bundle     = o_is_illegal ? ctrl_nop() : w_b;

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered, handshaked instruction decoder with a one-entry
// output register; mul/div stretched by MULDIV_LAT extra cycles.
// Latency 1 cycle (1+MULDIV_LAT for mul/div); backpressure via out_ready holds
// the bundle and drops in_ready; flush empties the stage, rst overrides all.
// Ports: clk/rst (sync, active high); in_valid/in_ready + instruction_type/func
//        in; flush; out_valid/out_ready + control bundle out; busy; illegal.
// Optional CTRL_ILLEGAL_TRAP_EN: makes `illegal` a sticky flag set by any
// accepted illegal encoding (cleared only by rst); otherwise it is tied to 0.
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int FUNC_W     = 5,
  parameter int ALUOP_W    = 3,
  parameter int MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         instruction_type,
  input  logic [FUNC_W-1:0]  func,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               BranchB,
  output logic               BranchI,
  output logic               BranchGEQ,
  output logic               BranchLEQ,
  output logic               MemToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               RegSrc2,
  output logic               RegSrc1,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               busy,
  output logic               illegal
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  ctrl_state_t      r_state;
  ctrl_bundle_t     r_bundle;
  logic             r_out_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  ctrl_bundle_t     w_dec;
  logic             w_is_illegal;
  logic             w_dec_muldiv;
  logic             w_in_ready;
  logic             w_accept;

  ctrl_decode #(
    .FUNC_W(FUNC_W)
  ) u_decode (
    .i_type      (instruction_type),
    .i_func      (func),
    .o_bundle    (w_dec),
    .o_is_illegal(w_is_illegal)
  );

  assign w_dec_muldiv = ctrl_is_muldiv(w_dec.alu_op);

  // Ready whenever the output register is empty or is being drained this
  // cycle; never while mul/div is stretching, and never in a flush cycle
  // so flush wins over a simultaneous in_valid.
  assign w_in_ready = !rst && !flush && (r_state != ST_MULDIV)
                      && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bundle    <= ctrl_nop();
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else if (flush) begin
      // Bundle contents are left as-is; out_valid=0 makes them meaningless
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            r_bundle <= w_dec;
            if (w_dec_muldiv) begin
              r_state     <= ST_MULDIV;
              r_cnt       <= CNT_LOAD;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
            end
          end else if (r_out_valid && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_MULDIV: begin
          // Counter runs LAT-1 .. 0, giving exactly MULDIV_LAT busy cycles
          if (r_cnt == '0) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky: only rst clears it; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_accept && w_is_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_is_illegal;
  assign illegal          = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign BranchB   = r_bundle.branch_b;
  assign BranchI   = r_bundle.branch_i;
  assign BranchGEQ = r_bundle.branch_geq;
  assign BranchLEQ = r_bundle.branch_leq;
  assign MemToReg  = r_bundle.mem_to_reg;
  assign MemRead   = r_bundle.mem_read;
  assign MemWrite  = r_bundle.mem_write;
  assign ALUSrc    = r_bundle.alu_src;
  assign RegWrite  = r_bundle.reg_write;
  assign RegSrc2   = r_bundle.reg_src2;
  assign RegSrc1   = r_bundle.reg_src1;
  assign ALUOp     = ALUOP_W'(r_bundle.alu_op);
  assign ImmSrc    = r_bundle.imm_src;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: transaction-level model plus per-cycle compare,
// with directed vectors and hand-computed literal expectations.
// Bundle vector layout: {BB,BI,BGEQ,BLEQ,M2R,MR,MW,ASRC,RW,RS2,RS1,ALUOp[2:0],ImmSrc}.
module tb_control_unit_pipe;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] instruction_type = 2'b00;
  logic [4:0] func = 5'd0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       BranchB, BranchI, BranchGEQ, BranchLEQ, MemToReg, MemRead;
  logic       MemWrite, ALUSrc, RegWrite, RegSrc2, RegSrc1;
  logic [2:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       busy;
  logic       illegal;

  control_unit_pipe #(.FUNC_W(5), .ALUOP_W(3), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_type(instruction_type), .func(func), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .BranchB(BranchB), .BranchI(BranchI), .BranchGEQ(BranchGEQ), .BranchLEQ(BranchLEQ),
    .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .RegSrc2(RegSrc2), .RegSrc1(RegSrc1),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {BranchB, BranchI, BranchGEQ, BranchLEQ, MemToReg, MemRead, MemWrite,
                    ALUSrc, RegWrite, RegSrc2, RegSrc1, ALUOp, ImmSrc};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] mk(input logic bb, bi, bg, bl, m2r, mr, mw,
                                     asrc, rw, rs2, rs1, input logic [2:0] aop,
                                     input logic [1:0] imm);
    return {bb, bi, bg, bl, m2r, mr, mw, asrc, rw, rs2, rs1, aop, imm};
  endfunction

  // Returns {illegal, bundle}
  function automatic logic [16:0] model_decode(input logic [1:0] t, input logic [4:0] f);
    logic [15:0] b;
    logic        ill;
    b   = '0;
    ill = 1'b1;
    if (t == 2'b00) begin
      ill = 1'b0;
      if (f[4]) b = mk(0,0,0,0, 0,0,1, 1,0,0,0, 3'd0, 2'b01);
      else      b = mk(0,0,0,0, 1,1,0, 1,1,0,0, 3'd0, 2'b01);
    end else if (t == 2'b01) begin
      for (int k = 0; k < 4; k++)
        if (f == 5'(k)) begin b = mk(0,0,0,0, 0,0,0, 0,1,0,0, 3'(k), 2'b00); ill = 1'b0; end
      for (int k = 0; k < 7; k++)
        if (f == 5'(20 + k)) begin b = mk(0,0,0,0, 0,0,0, 1,1,0,0, 3'(k), 2'b10); ill = 1'b0; end
    end else if (t == 2'b10) begin
      ill = 1'b0;
      b = mk(f[4:3] == 2'b00, f[4:3] == 2'b10, f[4:3] == 2'b01, f[4:3] == 2'b11,
             0,0,0, 0,0,1,1, 3'd1, 2'b00);
    end
    if (ill) b = '0;
    return {ill, b};
  endfunction

  logic        m_valid = 1'b0;
  logic [15:0] m_bundle = '0;
  int          m_busy = 0;    // remaining stretch cycles
  logic        m_ill = 1'b0;

  function automatic logic exp_rdy();
    return !rst && !flush && (m_busy == 0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    logic [16:0] d;
    d = model_decode(instruction_type, func);
    if (rst) begin
      m_valid = 1'b0; m_busy = 0; m_bundle = '0; m_ill = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0; m_busy = 0;
    end else if (in_valid && exp_rdy()) begin
      m_bundle = d[15:0];
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (d[16]) m_ill = 1'b1;
`endif
      if (d[4:2] == 3'd2 || d[4:2] == 3'd3) begin
        m_busy = LAT; m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
      end
    end else if (m_busy != 0) begin
      m_busy = m_busy - 1;
      if (m_busy == 0) m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_in_ready", 32'(in_ready), 32'(exp_rdy()));
      chk("cmp_busy", 32'(busy), 32'(m_busy != 0));
      chk("cmp_illegal", 32'(illegal), 32'(m_ill));
      if (m_valid) chk("cmp_bundle", 32'(dut_vec), 32'(m_bundle));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [1:0] t; logic [4:0] f; } vec_t;
  vec_t tbl [$];

  initial begin
    int nb, lat, n;
    logic [2:0] aop;
    logic seen;

    // Reset with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; instruction_type = 2'b01; func = 5'd0;
    tick(); chk_en = 1'b1; tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bundle", 32'(dut_vec), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    // Streaming: sub then branch-GEQ back to back
    out_ready = 1'b1; in_valid = 1'b1; instruction_type = 2'b01; func = 5'b00001;
    tick();
    chk("strm_sub", 32'(dut_vec), 32'h0084);
    instruction_type = 2'b10; func = 5'b01000; #1;
    chk("strm_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("strm_geq", 32'(dut_vec), 32'h2064);
    chk("strm_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("strm_drain", 32'(out_valid), 32'd0);

    // Mul/div: div stretched by LAT cycles
    in_valid = 1'b1; instruction_type = 2'b01; func = 5'b00011;
    tick();
    in_valid = 1'b0;
    nb = 0; lat = 0; aop = '0;
    for (int i = 1; i <= 8; i++) begin
      if (busy) nb++;
      if (out_valid && lat == 0) begin lat = i; aop = ALUOp; end
      tick();
    end
    chk("md_busy_cycles", 32'(nb), 32'd4);
    chk("md_latency", 32'(lat), 32'd5);
    chk("md_aluop", 32'(aop), 32'd3);

    // Backpressure: load held for 3 cycles while an add waits
    out_ready = 1'b0; in_valid = 1'b1; instruction_type = 2'b00; func = 5'b00000;
    tick();
    instruction_type = 2'b01; func = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold", 32'(dut_vec), 32'h0D81);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("bp_next_add", 32'(dut_vec), 32'h0080);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // Flush beats a simultaneous in_valid
    flush = 1'b1; in_valid = 1'b1; instruction_type = 2'b01; func = 5'b00001; #1;
    chk("flush_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("flush_no_accept", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Flush two cycles into a mul
    in_valid = 1'b1; instruction_type = 2'b01; func = 5'b00010;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flmd_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("flmd_never_valid", 32'(seen), 32'd0);
    in_valid = 1'b1; instruction_type = 2'b01; func = 5'b00000; #1;
    chk("flmd_add_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("flmd_add_valid", 32'(out_valid), 32'd1);
    chk("flmd_add_bundle", 32'(dut_vec), 32'h0080);
    in_valid = 1'b0;
    tick();

    // Illegal: reserved type emits NOP; sticky flag survives flush, not rst
    in_valid = 1'b1; instruction_type = 2'b11; func = 5'b00000;
    tick();
    in_valid = 1'b0;
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_nop", 32'(dut_vec), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_flag", 32'(illegal), 32'd1);
`else
    chk("ill_flag_off", 32'(illegal), 32'd0);
`endif
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_after_flush", 32'(illegal), 32'd1);
`else
    chk("ill_after_flush_off", 32'(illegal), 32'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ill_after_rst", 32'(illegal), 32'd0);
    tick();

    // Decode table through the handshake (model checks every cycle)
    tbl.push_back('{2'b00, 5'b10000});   // store
    tbl.push_back('{2'b01, 5'b11010});   // imm op 6
    tbl.push_back('{2'b10, 5'b10000});   // BranchI
    tbl.push_back('{2'b10, 5'b11000});   // BranchLEQ
    tbl.push_back('{2'b10, 5'b00111});   // BranchB
    tbl.push_back('{2'b01, 5'b10110});   // imm mul, stretched
    tbl.push_back('{2'b01, 5'b10100});   // imm add
    tbl.push_back('{2'b01, 5'b10000});   // illegal data
    tbl.push_back('{2'b01, 5'b00100});   // illegal data
    tbl.push_back('{2'b01, 5'b11011});   // illegal data
    tbl.push_back('{2'b01, 5'b00010});   // mul
    tbl.push_back('{2'b00, 5'b01111});   // load
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_valid = 1'b1; instruction_type = tbl[i].t; func = tbl[i].f; #1;
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("tbl_accept_timeout", 32'(n >= 20), 32'd0);
      tick();
      if (i == 0) chk("tbl_store", 32'(dut_vec), 32'h0301);
      if (i == 1) chk("tbl_imm6", 32'(dut_vec), 32'h019A);
      if (i == 2) chk("tbl_bri", 32'(dut_vec), 32'h4064);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Registered, handshaked successor of the combinational instruction decoder. It decodes `instruction_type`/`func` into the datapath control bundle and holds the result in a one-entry output register between decode and execute. It stretches multi-cycle mul/div operations with an internal counter, and supports pipeline stall (backpressure) and flush.

## Interface
Parameters:
- `FUNC_W`, 5: width of `func`; decode uses `func[4:0]`, and any upper bits must be zero for a legal encoding.
- `ALUOP_W`, 3: width of `ALUOp`, must be ≥ 3.
- `MULDIV_LAT`, 4: extra execute cycles for mult/div (ALUOp 010/011); range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: decoder accepts this cycle.
- `instruction_type` in 2: 00 mem, 01 data, 10 control, 11 reserved.
- `func` in FUNC_W: function field.
- `flush` in 1: discard held and in-flight decode.
- `out_valid` out 1: control bundle valid.
- `out_ready` in 1: execute stage consumes bundle.
- `BranchB`, `BranchI`, `BranchGEQ`, `BranchLEQ`, `MemToReg`, `MemRead`, `MemWrite`, `ALUSrc`, `RegWrite`, `RegSrc2`, `RegSrc1` out 1 each: control bundle.
- `ALUOp` out ALUOP_W: ALU operation.
- `ImmSrc` out 2: immediate format.
- `busy` out 1: mul/div counter running.
- `illegal` out 1: sticky illegal-encoding flag (see Configuration).

## Operation
- Decode table, with no x outputs (all don't-cares drive 0):
  - Type 01 with func[4]=0: 00000 add, 00001 sub, 00010 mul, 00011 div → ALUOp 0/1/2/3; RegWrite=1; ALUSrc=0.
  - Type 01 with func[4]=1: 10100..11010 → ALUOp 0..6; ALUSrc=1; RegWrite=1; ImmSrc=10.
  - Type 10: func[4:3] 00 → BranchB, 10 → BranchI, 01 → BranchGEQ, 11 → BranchLEQ; ALUOp=001; ImmSrc=00; RegSrc2=RegSrc1=1.
  - Type 00: ALUSrc=1, ALUOp=000, ImmSrc=01. func[4]=1 is store (MemWrite=1). func[4]=0 is load (MemRead=1, MemToReg=1, RegWrite=1).
- Illegal encodings decode to an all-zero bundle (NOP) that still flows through the handshake. Illegal means: type 11, an unlisted data func, or nonzero func above bit 4.
- FSM states:
  - IDLE: `in_ready = !out_valid | out_ready`.
  - HOLD: bundle registered, waiting for `out_ready`.
  - MULDIV: counter running, `out_valid=0`, `in_ready=0`.
- FSM transitions:
  - IDLE or HOLD with accept of mul/div → MULDIV, counter loaded with MULDIV_LAT−1.
  - MULDIV → HOLD when the counter reaches 0.
  - Any accept of another op → HOLD.
  - HOLD with `out_ready` and no new accept → IDLE.
- Reset: every output is 0, state is IDLE, the counter is 0, and `illegal` is cleared.

## Timing
- Decode latency is 1 cycle: fields accepted at edge N produce a bundle with `out_valid=1` after edge N.
- Mul/div latency is 1+MULDIV_LAT cycles from accept to `out_valid`.
- Bundle outputs are stable while `out_valid & !out_ready`.
- Back-to-back operation: with `out_ready` held high, one non-mul/div instruction is accepted every cycle.
- `flush`:
  - Clears `out_valid` and `busy` on the next edge and forces IDLE.
  - Forces `in_ready=0` in the flush cycle, so flush wins over a simultaneous `in_valid`.
- `rst` overrides `flush` and the handshake.
- A reset during MULDIV aborts the operation with no output.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An accepted illegal encoding sets `illegal` on the next edge.
  - `illegal` is held until `rst` and is not cleared by `flush`.
- Macro undefined: `illegal` is tied to 0 and no detection logic is synthesised.

## Structure
- Shared package `ctrl_pkg` holds:
  - Localparams for type codes (TYPE_MEM/DATA/CTRL) and ALUOp codes (ALU_ADD..ALU_CLI).
  - Typedef `ctrl_bundle_t`, a packed struct of all bundle fields.
  - Function `ctrl_nop()` returning the all-zero bundle.
- One sub-module, `ctrl_decode`: purely combinational fields → `ctrl_bundle_t` plus an `is_illegal` flag.
- The top level holds the FSM, counter and output register.

## Test plan
- Reset: assert `rst` with `in_valid=1` → all outputs 0, `in_ready=1` after release.
- Streaming: type 01, func 00001, then type 10, func 01000, with `out_ready=1` → consecutive cycles give ALUOp=001 RegWrite=1, then BranchGEQ=1 ALUOp=001 RegSrc1=RegSrc2=1.
- Mul/div: type 01, func 00011, MULDIV_LAT=4 → `busy` high for 4 cycles, `out_valid` 5 cycles after accept with ALUOp=011, `in_ready=0` throughout.
- Backpressure: load (type 00, func 00000) with `out_ready=0` for 3 cycles → bundle held (MemRead=MemToReg=RegWrite=1, ImmSrc=01), `in_ready=0`, released when `out_ready=1`.
- Flush mid-MULDIV: flush 2 cycles into a mul → `out_valid` never rises, state IDLE, the next add is accepted normally.
- Illegal (macro defined): type 11 → NOP bundle emitted, `illegal=1`, still 1 after `flush`, 0 after `rst`.
